trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 7, maximum WAIT cycles before abort (legal range 1..15).
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  committing instruction raised a synchronous exception.
REQ-005 ex_cause  in  4  exception code; ex_pc in 32 faulting PC; ex_tval in 32 trap value.
REQ-006 mret_req  in  1  committing instruction is MRET.
REQ-007 inst_valid  in  1  an instruction boundary exists this cycle; inst_pc in 32 is its PC.
REQ-008 irq_msip, irq_mtip, irq_meip  in  1 each  software/timer/external interrupt pending, level.
REQ-009 mstatus_mie  in  1  global machine interrupt enable; mie in 32 per-source enables (bits 3, 7, 11).
REQ-010 csr_exception, csr_mret  in  1 each  CSR-unit registered trap/return acknowledge.
REQ-011 csr_mtvec, csr_mepc  in  32 each  trap target and return target from the CSR unit.
REQ-012 trap_exception, trap_mret  out  1 each  one-cycle request to the CSR unit.
REQ-013 trap_epc out 32, trap_ecause out 4, trap_etval out 32, trap_int out 1 (cause is an interrupt).
REQ-014 flush  out  1  kill all in-flight instructions; busy out 1 controller not IDLE.
REQ-015 redirect_valid  out  1  one-cycle fetch redirect; redirect_pc out 32 its target.
REQ-016 ack_err  out  1  one-cycle pulse, acknowledge timeout.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; busy = (state != IDLE).
REQ-018 In IDLE, events SHALL be prioritised ex_valid > interrupt > mret_req; one event accepted per trap.
REQ-019 Interrupt taken only when inst_valid=1, mstatus_mie=1 and enabled source pending; among sources MEI (code 11) > MSI (code 3) > MTI (code 7).
REQ-020 Accepted exception: epc=ex_pc, ecause=ex_cause, etval=ex_tval, int=0; interrupt: epc=inst_pc, ecause=code, etval=0, int=1.
REQ-021 On acceptance, state -> ISSUE and trap_epc/ecause/etval/int registered at the same edge; values held until next acceptance.
REQ-022 In ISSUE (exactly one cycle) trap_exception=1 for a trap or trap_mret=1 for MRET, never both; next state WAIT, wait counter cleared.
REQ-023 flush SHALL be 1 in the acceptance cycle and in every ISSUE and WAIT cycle.
REQ-024 In WAIT, matching ack (csr_exception for trap, csr_mret for MRET) -> redirect_valid=1 combinationally that cycle, redirect_pc=csr_mtvec (trap) or csr_mepc (MRET); next state IDLE.
REQ-025 Non-matching ack in WAIT SHALL be ignored.
REQ-026 WAIT counter 4 bits, increments each WAIT cycle without matching ack; reaching ACK_TIMEOUT -> ack_err=1 that cycle, no redirect, next state IDLE.
REQ-027 All inputs except acks SHALL be ignored while busy=1; events there are lost (upstream is flushed).
REQ-028 Nominal latency: event in cycle N -> trap request N+1 -> redirect N+2 -> IDLE and new acceptance possible N+3.
REQ-029 No interrupt taken when mstatus_mie=0 or source's mie bit is 0, regardless of irq level.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, counter 0, trap_epc/etval 0, trap_ecause 0, trap_int 0.
REQ-031 During and in the cycle after reset, trap_exception, trap_mret, flush, busy, redirect_valid, ack_err SHALL be 0.
REQ-032 Reset in ISSUE or WAIT SHALL abort the operation with no redirect and no ack_err pulse.

Verification
REQ-033 ex_valid=1, ex_cause=2, ex_pc=0x100, ex_tval=0xDEAD; csr_exception=1 next-next cycle, csr_mtvec=0x80 -> trap_exception one cycle at N+1 with epc 0x100, cause 2, tval 0xDEAD; redirect_valid at N+2, redirect_pc 0x80.
REQ-034 irq_mtip=irq_meip=1, mie=0x880, mstatus_mie=1, inst_valid=1, inst_pc=0x200 -> cause 11, trap_int=1, epc 0x200, etval 0.
REQ-035 ex_valid=1 and mret_req=1 and irq_meip=1 same cycle -> exception taken only; no trap_mret.
REQ-036 mret_req=1, csr_mret ack, csr_mepc=0x304 -> trap_mret one cycle, redirect_pc=0x304; csr_exception during WAIT ignored.
REQ-037 trap issued, no ack, ACK_TIMEOUT=7 -> ack_err pulse after 7 WAIT cycles, redirect_valid never 1, busy=0 next cycle.
REQ-038 rst=1 in WAIT -> IDLE next cycle, all outputs 0, later ack produces no redirect.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, interrupts and MRET, issues a one-cycle
// request to the CSR unit, then waits for its acknowledge to redirect fetch.
module trap_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_cause,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_tval,
    input  logic        mret_req,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        irq_msip,
    input  logic        irq_mtip,
    input  logic        irq_meip,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    input  logic        csr_exception,
    input  logic        csr_mret,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        trap_exception,
    output logic        trap_mret,
    output logic [31:0] trap_epc,
    output logic [3:0]  trap_ecause,
    output logic [31:0] trap_etval,
    output logic        trap_int,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ack_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] TIMEOUT = 4'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mret_q, mret_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic        int_q, int_d;

    logic        meip_en, msip_en, mtip_en, irq_take;
    logic [3:0]  irq_code;
    logic        ack_match;

    assign meip_en  = irq_meip & mie[11];
    assign msip_en  = irq_msip & mie[3];
    assign mtip_en  = irq_mtip & mie[7];
    assign irq_take = inst_valid & mstatus_mie & (meip_en | msip_en | mtip_en);
    assign irq_code = meip_en ? 4'd11 : (msip_en ? 4'd3 : 4'd7);
    assign ack_match = mret_q ? csr_mret : csr_exception;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mret_d         = mret_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        int_d          = int_q;
        trap_exception = 1'b0;
        trap_mret      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        ack_err        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Trap info is only replaced by an exception or interrupt; MRET keeps it.
                if (ex_valid) begin
                    state_d = ISSUE;
                    mret_d  = 1'b0;
                    epc_d   = ex_pc;
                    cause_d = ex_cause;
                    tval_d  = ex_tval;
                    int_d   = 1'b0;
                    flush   = 1'b1;
                end else if (irq_take) begin
                    state_d = ISSUE;
                    mret_d  = 1'b0;
                    epc_d   = inst_pc;
                    cause_d = irq_code;
                    tval_d  = 32'd0;
                    int_d   = 1'b1;
                    flush   = 1'b1;
                end else if (mret_req) begin
                    state_d = ISSUE;
                    mret_d  = 1'b1;
                    flush   = 1'b1;
                end
            end
            ISSUE: begin
                flush          = 1'b1;
                trap_exception = ~mret_q;
                trap_mret      = mret_q;
                cnt_d          = 4'd0;
                state_d        = WAIT;
            end
            WAIT: begin
                flush = 1'b1;
                if (ack_match) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = mret_q ? csr_mepc : csr_mtvec;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TIMEOUT) begin
                        ack_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pulses are suppressed while reset is held so an abort never leaks a redirect.
        if (rst) begin
            trap_exception = 1'b0;
            trap_mret      = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            ack_err        = 1'b0;
        end
    end

    assign busy        = (state_q != IDLE) & ~rst;
    assign trap_epc    = epc_q;
    assign trap_ecause = cause_q;
    assign trap_etval  = tval_q;
    assign trap_int    = int_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mret_q  <= 1'b0;
            epc_q   <= 32'd0;
            cause_q <= 4'd0;
            tval_q  <= 32'd0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mret_q  <= mret_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            int_q   <= int_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs change on the falling edge and are
// checked 1ns later, so combinational outputs reflect the current cycle.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mret_req, inst_valid;
    logic [3:0]  ex_cause;
    logic [31:0] ex_pc, ex_tval, inst_pc, mie, csr_mtvec, csr_mepc;
    logic        irq_msip, irq_mtip, irq_meip, mstatus_mie;
    logic        csr_exception, csr_mret;
    logic        trap_exception, trap_mret, trap_int, flush, busy;
    logic        redirect_valid, ack_err;
    logic [31:0] trap_epc, trap_etval, redirect_pc;
    logic [3:0]  trap_ecause;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.ACK_TIMEOUT(7)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_cause(ex_cause), .ex_pc(ex_pc), .ex_tval(ex_tval),
        .mret_req(mret_req), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .mstatus_mie(mstatus_mie), .mie(mie),
        .csr_exception(csr_exception), .csr_mret(csr_mret),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .trap_exception(trap_exception), .trap_mret(trap_mret),
        .trap_epc(trap_epc), .trap_ecause(trap_ecause), .trap_etval(trap_etval),
        .trap_int(trap_int), .flush(flush), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        ex_valid = 0; ex_cause = 0; ex_pc = 0; ex_tval = 0;
        mret_req = 0; inst_valid = 0; inst_pc = 0;
        irq_msip = 0; irq_mtip = 0; irq_meip = 0; mstatus_mie = 0; mie = 0;
        csr_exception = 0; csr_mret = 0; csr_mtvec = 0; csr_mepc = 0;
    endtask

    task automatic next();
        @(negedge clk);
        quiet();
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_texc"}, {31'd0, trap_exception}, 0);
        chk({tag, "_tmret"}, {31'd0, trap_mret}, 0);
        chk({tag, "_flush"}, {31'd0, flush}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_redir"}, {31'd0, redirect_valid}, 0);
        chk({tag, "_ackerr"}, {31'd0, ack_err}, 0);
    endtask

    initial begin
        quiet();
        rst = 1;
        // reset held
        next(); ex_valid = 1; #1;
        outs_zero("rst_hold");
        next(); rst = 0; #1;
        outs_zero("rst_after");
        chk("rst_epc", trap_epc, 0);
        chk("rst_cause", {28'd0, trap_ecause}, 0);
        chk("rst_tval", trap_etval, 0);
        chk("rst_int", {31'd0, trap_int}, 0);

        // exception, acked in WAIT
        next(); ex_valid = 1; ex_cause = 2; ex_pc = 32'h100; ex_tval = 32'hDEAD; #1;
        chk("exc_acc_flush", {31'd0, flush}, 1);
        chk("exc_acc_busy", {31'd0, busy}, 0);
        next(); #1;
        chk("exc_iss_texc", {31'd0, trap_exception}, 1);
        chk("exc_iss_tmret", {31'd0, trap_mret}, 0);
        chk("exc_iss_busy", {31'd0, busy}, 1);
        chk("exc_iss_epc", trap_epc, 32'h100);
        chk("exc_iss_cause", {28'd0, trap_ecause}, 2);
        chk("exc_iss_tval", trap_etval, 32'hDEAD);
        chk("exc_iss_int", {31'd0, trap_int}, 0);
        next(); csr_exception = 1; csr_mtvec = 32'h80; #1;
        chk("exc_wait_texc", {31'd0, trap_exception}, 0);
        chk("exc_redir", {31'd0, redirect_valid}, 1);
        chk("exc_redir_pc", redirect_pc, 32'h80);
        next(); #1;
        chk("exc_idle_busy", {31'd0, busy}, 0);
        chk("exc_idle_redir", {31'd0, redirect_valid}, 0);

        // interrupts masked: global disable, then source disable
        next(); irq_meip = 1; mie = 32'h880; inst_valid = 1; #1;
        chk("irq_gmask_flush", {31'd0, flush}, 0);
        next(); irq_msip = 1; mie = 32'h880; mstatus_mie = 1; inst_valid = 1; #1;
        chk("irq_smask_flush", {31'd0, flush}, 0);
        next(); irq_meip = 1; mie = 32'h800; mstatus_mie = 1; inst_valid = 0; #1;
        chk("irq_noinst_flush", {31'd0, flush}, 0);

        // MEI beats MTI
        next(); irq_mtip = 1; irq_meip = 1; mie = 32'h880; mstatus_mie = 1;
        inst_valid = 1; inst_pc = 32'h200; #1;
        chk("irq_acc_flush", {31'd0, flush}, 1);
        next(); #1;
        chk("irq_texc", {31'd0, trap_exception}, 1);
        chk("irq_cause", {28'd0, trap_ecause}, 11);
        chk("irq_int", {31'd0, trap_int}, 1);
        chk("irq_epc", trap_epc, 32'h200);
        chk("irq_tval", trap_etval, 0);
        next(); csr_exception = 1; csr_mtvec = 32'h84; #1;
        chk("irq_redir_pc", redirect_pc, 32'h84);

        // MSI beats MTI
        next(); irq_msip = 1; irq_mtip = 1; mie = 32'h88; mstatus_mie = 1;
        inst_valid = 1; inst_pc = 32'h240; #1;
        next(); #1;
        chk("msi_cause", {28'd0, trap_ecause}, 3);
        next(); csr_exception = 1; #1;

        // exception beats interrupt and MRET; events while busy are lost
        next(); ex_valid = 1; ex_cause = 5; ex_pc = 32'h300; ex_tval = 32'h11;
        mret_req = 1; irq_meip = 1; mie = 32'h800; mstatus_mie = 1; inst_valid = 1; #1;
        next(); ex_valid = 1; ex_cause = 9; ex_pc = 32'h999; #1;
        chk("prio_texc", {31'd0, trap_exception}, 1);
        chk("prio_tmret", {31'd0, trap_mret}, 0);
        chk("prio_cause", {28'd0, trap_ecause}, 5);
        chk("prio_int", {31'd0, trap_int}, 0);
        next(); ex_valid = 1; ex_cause = 9; ex_pc = 32'h999; csr_exception = 1; #1;
        chk("busy_ign_epc", trap_epc, 32'h300);
        next(); #1;

        // MRET with a stray trap ack ignored in WAIT
        next(); mret_req = 1; #1;
        chk("mret_acc_flush", {31'd0, flush}, 1);
        next(); #1;
        chk("mret_tmret", {31'd0, trap_mret}, 1);
        chk("mret_texc", {31'd0, trap_exception}, 0);
        next(); csr_exception = 1; csr_mtvec = 32'h80; #1;
        chk("mret_stray_redir", {31'd0, redirect_valid}, 0);
        chk("mret_stray_busy", {31'd0, busy}, 1);
        next(); csr_mret = 1; csr_mepc = 32'h304; #1;
        chk("mret_redir", {31'd0, redirect_valid}, 1);
        chk("mret_redir_pc", redirect_pc, 32'h304);
        next(); #1;
        chk("mret_idle_busy", {31'd0, busy}, 0);

        // ack timeout after 7 WAIT cycles
        next(); ex_valid = 1; ex_cause = 1; #1;
        next(); #1;
        chk("to_iss", {31'd0, trap_exception}, 1);
        for (int i = 1; i <= 7; i++) begin
            next(); csr_mret = 1; #1;
            chk($sformatf("to_w%0d_redir", i), {31'd0, redirect_valid}, 0);
            chk($sformatf("to_w%0d_ackerr", i), {31'd0, ack_err}, (i == 7) ? 1 : 0);
            chk($sformatf("to_w%0d_busy", i), {31'd0, busy}, 1);
        end
        next(); #1;
        chk("to_after_busy", {31'd0, busy}, 0);
        chk("to_after_ackerr", {31'd0, ack_err}, 0);

        // reset in WAIT aborts with no redirect
        next(); ex_valid = 1; ex_cause = 4; ex_pc = 32'h500; #1;
        next(); #1;
        next(); rst = 1; csr_exception = 1; csr_mtvec = 32'h80; #1;
        outs_zero("rstw_hold");
        next(); rst = 0; csr_exception = 1; csr_mtvec = 32'h80; #1;
        outs_zero("rstw_after");
        chk("rstw_epc", trap_epc, 0);
        chk("rstw_cause", {28'd0, trap_ecause}, 0);
        next(); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
